pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
Parametrised hazard-detection and forwarding controller for the 5-stage scalar/vector pipeline (IF, ID, EX, MEM, WB). It tracks in-flight destination registers for EX, MEM and WB, and generates four kinds of control: load-use stalls, branch flushes, EX-operand forwarding selects, and WB-to-ID register-file bypass. Scalar and vector register files are tracked as separate namespaces. It also keeps saturating stall and flush counters for performance debug.

Parameters:
- REG_AW, 5, register address width for both files.
- ZERO_REG, 1, 1 = scalar r0 is hardwired zero: never matched or forwarded. Vector v0 is always normal.
- LOAD_STALL, 1, load-use stall cycles: 1 = RAM data ready in WB; 2 = registered RAM output, so MEM-stage loads also stall.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rn, id_rm  in  REG_AW  ID source addresses.
- id_use_rn, id_use_rm  in  1  ID sources actually read.
- id_rd  in  REG_AW  ID destination.
- id_reg_write  in  1  ID writes a register.
- id_is_vec  in  1  1 = vector file for all of this instruction's operands.
- id_is_load  in  1  ID is a memory load.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- cnt_clr  in  1  clear counters.
- stall  out  1  hold PC and IF/ID; ID/EX loads a bubble.
- flush  out  1  clear IF/ID and ID/EX.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 = ID/EX register, 01 = EX/MEM ALU result, 10 = MEM/WB write-back value.
- wb_byp_a, wb_byp_b  out  1  ID reads must take the WB value.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Tracker: three stage records (EX, MEM, WB). Each record holds {valid, wr, vec, load, rd, use_rn, use_rm, rn, rm}; the source fields are used in EX only.
- Tracker update each clk: WB <= MEM; MEM <= EX.
- EX <= ID fields when id_valid & !stall & !flush; otherwise EX <= bubble (valid = 0).
- Match(src, stage): stage.valid & stage.wr & (stage.vec == src.vec) & (stage.rd == src.addr) & src.use & !(ZERO_REG & !src.vec & src.addr == 0).
- Load-use hazard: an ID source matches EX with EX.load. If LOAD_STALL = 2, an ID source matching MEM with MEM.load is also a hazard.
- stall = id_valid & hazard & !ex_branch_taken. Combinational output.
- flush = ex_branch_taken. Combinational. Flush has priority over stall: when both are true, stall = 0.
- Forwarding (combinational from the EX record vs the MEM/WB records): fwd_x_sel = 01 if the EX source matches MEM and !MEM.load; else 10 if it matches WB; else 00. A MEM match wins over a WB match (youngest producer).
- A MEM.load match with no WB match yields 00. Unreachable when stalls work; assertion target.
- wb_byp_x = ID source matches WB. The register file writes at the edge, so ID otherwise reads the stale value.
- Counters: incremented in the same cycle that stall or flush is asserted. Each saturates at 2^CNT_W-1 and never wraps.
- cnt_clr zeroes both counters. It has priority over an increment in the same cycle.
- Reset (rst = 0 at clk edge): all tracker valid bits are 0 and counters are 0. Consequently stall, flush (given ex_branch_taken = 0), fwd_*_sel and wb_byp_* are all 0 the cycle after.
- Reset mid-stall drops the stall immediately; the pending load record is discarded.
- Latency: hazard to stall is 0 cycles. With LOAD_STALL = 1, a load-use stall lasts exactly 1 cycle; the dependent instruction then enters EX with sel = 10.
- Back-to-back dependent loads each stall independently.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with random inputs -> stall = 0, fwd sels = 00, wb_byp = 0, counters = 0. ex_branch_taken = 0 gives flush = 0.
- ALU RAW: add r3 then sub r4,r3,r1 -> sub in EX has fwd_a_sel = 01. A distance-2 consumer gets 10. A distance-3 consumer gets wb_byp_a = 1 in ID.
- Load-use (LOAD_STALL = 1): ld r5 then add r6,r5,r5 -> stall = 1 for exactly 1 cycle, then fwd_a_sel = fwd_b_sel = 10, stall_cnt = 1. With LOAD_STALL = 2 -> 2 stall cycles, stall_cnt = 2.
- Namespaces/zero: scalar write r2 then vector read v2 -> no stall, sel = 00. Scalar write r0 then read r0 -> sel = 00. Vector write v0 then read v0 -> sel = 01.
- Stall+flush collision: load-use hazard and ex_branch_taken = 1 in the same cycle -> stall = 0, flush = 1, flush_cnt +1, stall_cnt unchanged, next EX record invalid.
- Counter saturation (CNT_W = 4): 20 flush cycles -> flush_cnt = 15. cnt_clr together with a flush -> 0.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - load-use stall, branch flush, EX forwarding and WB bypass control
module pipe_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int ZERO_REG   = 1,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_vec,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    input  logic              cnt_clr,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              wb_byp_a,
    output logic              wb_byp_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic              vec;
        logic              load;
        logic [REG_AW-1:0] rd;
    } dst_t;

    // WB never needs the load flag: nothing older than WB can be stalled against
    typedef struct packed {
        logic              valid;
        logic              wr;
        logic              vec;
        logic [REG_AW-1:0] rd;
    } wb_t;

    typedef struct packed {
        logic              use_rn;
        logic              use_rm;
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rm;
    } src_t;

    dst_t ex_q, ex_d, mem_q, mem_d;
    wb_t  wb_q, wb_d;
    src_t ex_src_q, ex_src_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic id_rn_ex, id_rm_ex, id_rn_mem, id_rm_mem, id_rn_wb, id_rm_wb;
    logic ex_rn_mem, ex_rm_mem, ex_rn_wb, ex_rm_wb;
    logic hazard;
    logic ex_mem_load_hit;

    function automatic logic dst_hit(
        input logic              valid,
        input logic              wr,
        input logic              dvec,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] addr,
        input logic              svec,
        input logic              use_src
    );
        logic zero_src;
        zero_src = (ZERO_REG != 0) && !svec && (addr == '0);
        return valid && wr && (dvec == svec) && (rd == addr) && use_src && !zero_src;
    endfunction

    always_comb begin
        id_rn_ex  = dst_hit(ex_q.valid, ex_q.wr, ex_q.vec, ex_q.rd, id_rn, id_is_vec, id_use_rn);
        id_rm_ex  = dst_hit(ex_q.valid, ex_q.wr, ex_q.vec, ex_q.rd, id_rm, id_is_vec, id_use_rm);
        id_rn_mem = dst_hit(mem_q.valid, mem_q.wr, mem_q.vec, mem_q.rd, id_rn, id_is_vec, id_use_rn);
        id_rm_mem = dst_hit(mem_q.valid, mem_q.wr, mem_q.vec, mem_q.rd, id_rm, id_is_vec, id_use_rm);
        id_rn_wb  = dst_hit(wb_q.valid, wb_q.wr, wb_q.vec, wb_q.rd, id_rn, id_is_vec, id_use_rn);
        id_rm_wb  = dst_hit(wb_q.valid, wb_q.wr, wb_q.vec, wb_q.rd, id_rm, id_is_vec, id_use_rm);

        ex_rn_mem = ex_q.valid &&
                    dst_hit(mem_q.valid, mem_q.wr, mem_q.vec, mem_q.rd, ex_src_q.rn, ex_q.vec, ex_src_q.use_rn);
        ex_rm_mem = ex_q.valid &&
                    dst_hit(mem_q.valid, mem_q.wr, mem_q.vec, mem_q.rd, ex_src_q.rm, ex_q.vec, ex_src_q.use_rm);
        ex_rn_wb  = ex_q.valid &&
                    dst_hit(wb_q.valid, wb_q.wr, wb_q.vec, wb_q.rd, ex_src_q.rn, ex_q.vec, ex_src_q.use_rn);
        ex_rm_wb  = ex_q.valid &&
                    dst_hit(wb_q.valid, wb_q.wr, wb_q.vec, wb_q.rd, ex_src_q.rm, ex_q.vec, ex_src_q.use_rm);
    end

    always_comb begin
        hazard = ex_q.load && (id_rn_ex || id_rm_ex);
        if (LOAD_STALL == 2) begin
            hazard = hazard || (mem_q.load && (id_rn_mem || id_rm_mem));
        end

        flush = ex_branch_taken;
        stall = id_valid && hazard && !ex_branch_taken;

        wb_byp_a = id_rn_wb;
        wb_byp_b = id_rm_wb;

        // a loaded value sitting in MEM is not yet available, so it is never forwarded
        fwd_a_sel = 2'b00;
        if (ex_rn_mem && !mem_q.load) begin
            fwd_a_sel = 2'b01;
        end else if (ex_rn_wb) begin
            fwd_a_sel = 2'b10;
        end
        fwd_b_sel = 2'b00;
        if (ex_rm_mem && !mem_q.load) begin
            fwd_b_sel = 2'b01;
        end else if (ex_rm_wb) begin
            fwd_b_sel = 2'b10;
        end

        ex_mem_load_hit = mem_q.load && (ex_rn_mem || ex_rm_mem);
    end

    always_comb begin
        ex_d     = '0;
        ex_src_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.valid      = 1'b1;
            ex_d.wr         = id_reg_write;
            ex_d.vec        = id_is_vec;
            ex_d.load       = id_is_load;
            ex_d.rd         = id_rd;
            ex_src_d.use_rn = id_use_rn;
            ex_src_d.use_rm = id_use_rm;
            ex_src_d.rn     = id_rn;
            ex_src_d.rm     = id_rm;
        end
        mem_d      = ex_q;
        wb_d.valid = mem_q.valid;
        wb_d.wr    = mem_q.wr;
        wb_d.vec   = mem_q.vec;
        wb_d.rd    = mem_q.rd;

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q        <= '0;
            ex_src_q    <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            ex_src_q    <= ex_src_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // load-use stalls must keep a consumer out of EX while its load is still in MEM
    ex_mem_load_hit_a: assert property (@(posedge clk) disable iff (!rst) !ex_mem_load_hit);

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed and randomized checks of pipe_hazard_unit against a stage-history model
module tb_pipe_hazard_unit;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, id_valid, id_use_rn, id_use_rm, id_reg_write, id_is_vec, id_is_load;
    logic          ex_branch_taken, cnt_clr;
    logic [AW-1:0] id_rn, id_rm, id_rd;

    logic        st1, fl1, ba1, bb1, st2, fl2, ba2, bb2;
    logic [1:0]  fa1, fb1, fa2, fb2;
    logic [15:0] sc1, fc1;
    logic [3:0]  sc2, fc2;

    logic        stall_o [2];
    logic        flush_o [2];
    logic [1:0]  fa_o [2];
    logic [1:0]  fb_o [2];
    logic        ba_o [2];
    logic        bb_o [2];
    logic [15:0] sc_o [2];
    logic [15:0] fc_o [2];

    assign stall_o[0] = st1;  assign stall_o[1] = st2;
    assign flush_o[0] = fl1;  assign flush_o[1] = fl2;
    assign fa_o[0] = fa1;     assign fa_o[1] = fa2;
    assign fb_o[0] = fb1;     assign fb_o[1] = fb2;
    assign ba_o[0] = ba1;     assign ba_o[1] = ba2;
    assign bb_o[0] = bb1;     assign bb_o[1] = bb2;
    assign sc_o[0] = sc1;     assign sc_o[1] = {12'd0, sc2};
    assign fc_o[0] = fc1;     assign fc_o[1] = {12'd0, fc2};

    pipe_hazard_unit #(.REG_AW(AW), .ZERO_REG(1), .LOAD_STALL(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_vec(id_is_vec), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .cnt_clr(cnt_clr), .stall(st1), .flush(fl1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
        .wb_byp_a(ba1), .wb_byp_b(bb1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    pipe_hazard_unit #(.REG_AW(AW), .ZERO_REG(1), .LOAD_STALL(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_vec(id_is_vec), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .cnt_clr(cnt_clr), .stall(st2), .flush(fl2), .fwd_a_sel(fa2), .fwd_b_sel(fb2),
        .wb_byp_a(ba2), .wb_byp_b(bb2), .stall_cnt(sc2), .flush_cnt(fc2)
    );

    typedef struct {
        bit v; bit wr; bit vec; bit ld; int rd;
        bit urn; bit urm; int rn; int rm;
    } inst_t;

    // pm[k][0..2] = instruction occupying EX, MEM, WB of instance k
    inst_t pm [2][3];
    int    sc_m [2];
    int    fc_m [2];
    int    checks = 0;
    int    errors = 0;

    function automatic inst_t bubble();
        inst_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic bit hit(inst_t p, int a, bit vec, bit u);
        return p.v && p.wr && (p.vec == vec) && (p.rd == a) && u && !(!vec && a == 0);
    endfunction

    function automatic bit m_stall(inst_t p [3], int ls);
        bit hz = 1'b0;
        for (int s = 0; s < ls; s++) begin
            if (p[s].ld && (hit(p[s], int'(id_rn), id_is_vec, id_use_rn) ||
                            hit(p[s], int'(id_rm), id_is_vec, id_use_rm))) hz = 1'b1;
        end
        return id_valid && hz && !ex_branch_taken;
    endfunction

    function automatic int m_fwd(inst_t p [3], bit b_side);
        int a = b_side ? p[0].rm : p[0].rn;
        bit u = b_side ? p[0].urm : p[0].urn;
        if (!p[0].v) return 0;
        if (hit(p[1], a, p[0].vec, u) && !p[1].ld) return 1;
        if (hit(p[2], a, p[0].vec, u)) return 2;
        return 0;
    endfunction

    function automatic bit m_byp(inst_t p [3], bit b_side);
        if (b_side) return hit(p[2], int'(id_rm), id_is_vec, id_use_rm);
        return hit(p[2], int'(id_rn), id_is_vec, id_use_rn);
    endfunction

    task automatic tick();
        inst_t n;
        bit    st;
        int    cmax;
        n.v = 1'b1; n.wr = id_reg_write; n.vec = id_is_vec; n.ld = id_is_load; n.rd = int'(id_rd);
        n.urn = id_use_rn; n.urm = id_use_rm; n.rn = int'(id_rn); n.rm = int'(id_rm);
        for (int k = 0; k < 2; k++) begin
            st   = m_stall(pm[k], k + 1);
            cmax = (k == 0) ? 65535 : 15;
            if (!rst) begin
                for (int s = 0; s < 3; s++) pm[k][s] = bubble();
                sc_m[k] = 0;
                fc_m[k] = 0;
            end else begin
                pm[k][2] = pm[k][1];
                pm[k][1] = pm[k][0];
                pm[k][0] = (id_valid && !st && !ex_branch_taken) ? n : bubble();
                if (cnt_clr) begin
                    sc_m[k] = 0;
                    fc_m[k] = 0;
                end else begin
                    if (st && sc_m[k] < cmax) sc_m[k]++;
                    if (ex_branch_taken && fc_m[k] < cmax) fc_m[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input bit wr, input bit ld, input bit vec, input int rd,
                          input bit urn, input int rn, input bit urm, input int rm);
        id_valid = v; id_reg_write = wr; id_is_load = ld; id_is_vec = vec; id_rd = AW'(rd);
        id_use_rn = urn; id_rn = AW'(rn); id_use_rm = urm; id_rm = AW'(rm);
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_inputs();
        id_valid = $urandom_range(0, 3) != 0; id_reg_write = $urandom_range(0, 1);
        id_is_load = $urandom_range(0, 2) == 0; id_is_vec = $urandom_range(0, 3) == 0;
        id_rd = AW'($urandom_range(0, 3)); id_rn = AW'($urandom_range(0, 3)); id_rm = AW'($urandom_range(0, 3));
        id_use_rn = $urandom_range(0, 1); id_use_rm = $urandom_range(0, 1);
    endtask

    task automatic clear_counters();
        nop();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; cnt_clr = 1'b0; ex_branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            cnt_clr = $urandom_range(0, 1);
            tick();
        end
        rand_inputs();
        cnt_clr = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (stall_o[k] !== 1'b0) begin errors++; $display("FAIL reset_stall%0d got=%0b exp=0", k, stall_o[k]); end
            checks++; if (flush_o[k] !== 1'b0) begin errors++; $display("FAIL reset_flush%0d got=%0b exp=0", k, flush_o[k]); end
            checks++; if (fa_o[k] !== 2'd0 || fb_o[k] !== 2'd0) begin errors++; $display("FAIL reset_fwd%0d got=%0d/%0d exp=0/0", k, fa_o[k], fb_o[k]); end
            checks++; if (ba_o[k] !== 1'b0 || bb_o[k] !== 1'b0) begin errors++; $display("FAIL reset_byp%0d got=%0b/%0b exp=0/0", k, ba_o[k], bb_o[k]); end
            checks++; if (sc_o[k] !== 16'd0 || fc_o[k] !== 16'd0) begin errors++; $display("FAIL reset_cnt%0d got=%0d/%0d exp=0/0", k, sc_o[k], fc_o[k]); end
        end
        rst = 1'b1;
        nop();
        tick();
    endtask

    task automatic test_alu_raw();
        set_id(1, 1, 0, 0, 3, 1, 1, 1, 2); tick();
        set_id(1, 1, 0, 0, 4, 1, 3, 1, 1); tick();
        nop();
        for (int k = 0; k < 2; k++) begin
            checks++; if (fa_o[k] !== 2'd1 || fb_o[k] !== 2'd0) begin errors++; $display("FAIL raw_dist1_%0d got=%0d/%0d exp=1/0", k, fa_o[k], fb_o[k]); end
        end
        set_id(1, 1, 0, 0, 7, 1, 1, 1, 2); tick();
        nop(); tick();
        set_id(1, 1, 0, 0, 8, 1, 7, 1, 1); tick();
        nop();
        for (int k = 0; k < 2; k++) begin
            checks++; if (fa_o[k] !== 2'd2) begin errors++; $display("FAIL raw_dist2_%0d got=%0d exp=2", k, fa_o[k]); end
        end
        set_id(1, 1, 0, 0, 9, 1, 1, 1, 2); tick();
        nop(); tick();
        nop(); tick();
        set_id(1, 1, 0, 0, 10, 1, 9, 1, 9);
        checks++; if (ba_o[0] !== 1'b1 || bb_o[0] !== 1'b1) begin errors++; $display("FAIL raw_dist3_byp got=%0b/%0b exp=1/1", ba_o[0], bb_o[0]); end
        tick();
        nop(); tick();
    endtask

    task automatic test_load_use();
        nop(); tick(); nop(); tick();
        clear_counters();
        set_id(1, 1, 1, 0, 5, 1, 1, 0, 0); tick();
        set_id(1, 1, 0, 0, 6, 1, 5, 1, 5);
        checks++; if (stall_o[0] !== 1'b1 || stall_o[1] !== 1'b1) begin errors++; $display("FAIL lu_stall_c0 got=%0b/%0b exp=1/1", stall_o[0], stall_o[1]); end
        tick();
        #1;
        checks++; if (stall_o[0] !== 1'b0 || stall_o[1] !== 1'b1) begin errors++; $display("FAIL lu_stall_c1 got=%0b/%0b exp=0/1", stall_o[0], stall_o[1]); end
        checks++; if (sc_o[0] !== 16'd1) begin errors++; $display("FAIL lu_cnt1_c1 got=%0d exp=1", sc_o[0]); end
        tick();
        #1;
        checks++; if (fa_o[0] !== 2'd2 || fb_o[0] !== 2'd2) begin errors++; $display("FAIL lu_fwd1 got=%0d/%0d exp=2/2", fa_o[0], fb_o[0]); end
        checks++; if (stall_o[1] !== 1'b0 || ba_o[1] !== 1'b1 || bb_o[1] !== 1'b1) begin errors++; $display("FAIL lu_ls2_release got=%0b/%0b/%0b exp=0/1/1", stall_o[1], ba_o[1], bb_o[1]); end
        checks++; if (sc_o[0] !== 16'd1 || sc_o[1] !== 16'd2) begin errors++; $display("FAIL lu_cnt got=%0d/%0d exp=1/2", sc_o[0], sc_o[1]); end
        tick();
        nop();
        checks++; if (sc_o[1] !== 16'd2 || stall_o[1] !== 1'b0) begin errors++; $display("FAIL lu_ls2_done got=%0d/%0b exp=2/0", sc_o[1], stall_o[1]); end
        tick();
    endtask

    task automatic test_namespace();
        nop(); tick(); nop(); tick(); nop(); tick();
        set_id(1, 1, 1, 0, 2, 0, 0, 0, 0); tick();
        set_id(1, 1, 0, 1, 4, 1, 2, 1, 2);
        for (int k = 0; k < 2; k++) begin
            checks++; if (stall_o[k] !== 1'b0) begin errors++; $display("FAIL ns_vec_stall%0d got=%0b exp=0", k, stall_o[k]); end
        end
        tick();
        nop();
        checks++; if (fa_o[0] !== 2'd0 || fb_o[0] !== 2'd0) begin errors++; $display("FAIL ns_vec_fwd got=%0d/%0d exp=0/0", fa_o[0], fb_o[0]); end
        set_id(1, 1, 1, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 1, 0, 0, 6, 1, 0, 1, 0);
        checks++; if (stall_o[0] !== 1'b0) begin errors++; $display("FAIL ns_r0_stall got=%0b exp=0", stall_o[0]); end
        tick();
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 1, 0, 0, 7, 1, 0, 1, 0); tick();
        nop();
        checks++; if (fa_o[0] !== 2'd0 || fb_o[0] !== 2'd0) begin errors++; $display("FAIL ns_r0_fwd got=%0d/%0d exp=0/0", fa_o[0], fb_o[0]); end
        set_id(1, 1, 0, 1, 0, 0, 0, 0, 0); tick();
        set_id(1, 1, 0, 1, 1, 1, 0, 1, 0); tick();
        nop();
        for (int k = 0; k < 2; k++) begin
            checks++; if (fa_o[k] !== 2'd1 || fb_o[k] !== 2'd1) begin errors++; $display("FAIL ns_v0_fwd%0d got=%0d/%0d exp=1/1", k, fa_o[k], fb_o[k]); end
        end
        tick();
    endtask

    task automatic test_collision();
        nop(); tick(); nop(); tick();
        clear_counters();
        set_id(1, 1, 1, 0, 5, 0, 0, 0, 0); tick();
        set_id(1, 1, 1, 0, 8, 1, 5, 0, 0);
        ex_branch_taken = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (stall_o[k] !== 1'b0 || flush_o[k] !== 1'b1) begin errors++; $display("FAIL col_out%0d got=%0b/%0b exp=0/1", k, stall_o[k], flush_o[k]); end
        end
        tick();
        ex_branch_taken = 1'b0;
        set_id(1, 1, 0, 0, 9, 1, 8, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks++; if (stall_o[k] !== 1'b0) begin errors++; $display("FAIL col_bubble%0d got=%0b exp=0", k, stall_o[k]); end
            checks++; if (fc_o[k] !== 16'd1 || sc_o[k] !== 16'd0) begin errors++; $display("FAIL col_cnt%0d got=%0d/%0d exp=1/0", k, fc_o[k], sc_o[k]); end
        end
        tick();
        nop(); tick();
    endtask

    task automatic test_back_to_back();
        bit exp_st [5] = '{0, 1, 0, 1, 0};
        nop(); tick(); nop(); tick();
        clear_counters();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0:       set_id(1, 1, 1, 0, 1, 0, 0, 0, 0);
                1, 2:    set_id(1, 1, 1, 0, 2, 1, 1, 0, 0);
                default: set_id(1, 1, 0, 0, 3, 1, 2, 1, 2);
            endcase
            checks++; if (stall_o[0] !== exp_st[c]) begin errors++; $display("FAIL b2b_stall_c%0d got=%0b exp=%0b", c, stall_o[0], exp_st[c]); end
            tick();
        end
        nop();
        checks++; if (sc_o[0] !== 16'd2) begin errors++; $display("FAIL b2b_cnt got=%0d exp=2", sc_o[0]); end
        tick();
    endtask

    task automatic test_saturation();
        clear_counters();
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            tick();
        end
        nop();
        checks++; if (fc_o[1] !== 16'd15) begin errors++; $display("FAIL sat_flush4 got=%0d exp=15", fc_o[1]); end
        checks++; if (fc_o[0] !== 16'd20) begin errors++; $display("FAIL sat_flush16 got=%0d exp=20", fc_o[0]); end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        ex_branch_taken = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (fc_o[k] !== 16'd0) begin errors++; $display("FAIL sat_clr%0d got=%0d exp=0", k, fc_o[k]); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            ex_branch_taken = $urandom_range(0, 11) == 0;
            cnt_clr = $urandom_range(0, 29) == 0;
            rst = $urandom_range(0, 49) != 0;
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++; if (stall_o[k] !== m_stall(pm[k], k + 1)) begin errors++; $display("FAIL rnd_stall%0d c=%0d got=%0b exp=%0b", k, c, stall_o[k], m_stall(pm[k], k + 1)); end
                checks++; if (flush_o[k] !== ex_branch_taken) begin errors++; $display("FAIL rnd_flush%0d c=%0d got=%0b exp=%0b", k, c, flush_o[k], ex_branch_taken); end
                checks++; if (int'(fa_o[k]) != m_fwd(pm[k], 0) || int'(fb_o[k]) != m_fwd(pm[k], 1)) begin errors++; $display("FAIL rnd_fwd%0d c=%0d got=%0d/%0d exp=%0d/%0d", k, c, fa_o[k], fb_o[k], m_fwd(pm[k], 0), m_fwd(pm[k], 1)); end
                checks++; if (ba_o[k] !== m_byp(pm[k], 0) || bb_o[k] !== m_byp(pm[k], 1)) begin errors++; $display("FAIL rnd_byp%0d c=%0d got=%0b/%0b exp=%0b/%0b", k, c, ba_o[k], bb_o[k], m_byp(pm[k], 0), m_byp(pm[k], 1)); end
                checks++; if (int'(sc_o[k]) != sc_m[k] || int'(fc_o[k]) != fc_m[k]) begin errors++; $display("FAIL rnd_cnt%0d c=%0d got=%0d/%0d exp=%0d/%0d", k, c, sc_o[k], fc_o[k], sc_m[k], fc_m[k]); end
            end
            tick();
        end
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        cnt_clr = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) pm[k][s] = bubble();
            sc_m[k] = 0;
            fc_m[k] = 0;
        end
        rst = 1'b0; cnt_clr = 1'b0; ex_branch_taken = 1'b0;
        id_valid = 1'b0; id_reg_write = 1'b0; id_is_load = 1'b0; id_is_vec = 1'b0;
        id_use_rn = 1'b0; id_use_rm = 1'b0; id_rn = '0; id_rm = '0; id_rd = '0;
        test_reset();
        test_alu_raw();
        test_load_use();
        test_namespace();
        test_collision();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
